// File: rtl/ring_delay.sv
// Programmable delay line on a circular buffer, advanced only on enabled cycles.
// Define RING_DELAY_VALID_EN to carry valid_in through the line alongside the data.
module ring_delay #(
  parameter int data_width = 24,
  parameter int max_delay  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [$clog2(max_delay):0]  delay,
  input  logic [data_width-1:0]       data_in,
  input  logic                        valid_in,
  output logic [data_width-1:0]       data_out,
  output logic                        valid_out
);

  localparam int AW = $clog2(max_delay);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] MAXD = DW'(max_delay);

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    if (d == '0)
      return DW'(1);
    else if (d > MAXD)
      return MAXD;
    else
      return d;
  endfunction

  logic [data_width-1:0] mem [max_delay];
  logic [AW-1:0]         wp;
  logic [DW-1:0]         fill;
  logic [DW-1:0]         dq;
  logic [DW-1:0]         dclamp;
  logic                  flush;
  logic                  primed;
  logic [AW-1:0]         ra;
  logic [data_width-1:0] rd;

  assign dclamp = clamp_delay(delay);
  assign flush  = (dclamp != dq);
  // Enough history exists once the current sample plus stored ones cover dq stages.
  assign primed = ((fill + DW'(1)) >= dq);
  // Entry wp-k holds the sample from k enabled cycles ago; dq=1 bypasses storage.
  assign ra     = wp - AW'(dq - DW'(1));
  assign rd     = (dq == DW'(1)) ? data_in : mem[ra];

  always_ff @(posedge clk) begin
    if (!rst && !flush && en)
      mem[wp] <= data_in;
  end

`ifdef RING_DELAY_VALID_EN
  logic vmem [max_delay];
  logic vrd;

  assign vrd = (dq == DW'(1)) ? valid_in : vmem[ra];

  always_ff @(posedge clk) begin
    if (!rst && !flush && en)
      vmem[wp] <= valid_in;
  end
`else
  logic vrd;
  logic unused_valid_in;

  assign vrd             = 1'b1;
  assign unused_valid_in = valid_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      fill      <= '0;
      dq        <= dclamp;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      dq        <= dclamp;
      fill      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      wp        <= wp + AW'(1);
      fill      <= (fill == MAXD) ? fill : fill + DW'(1);
      data_out  <= primed ? rd : '0;
      valid_out <= primed & vrd;
    end
  end

endmodule

// File: tb/tb_ring_delay.sv
// Self-checking bench for ring_delay: directed cases plus randomized traffic
// checked every cycle against a queue-based shift-register model.
module tb_ring_delay;

  localparam int DWID = 24;
  localparam int MAXD = 16;

  logic            clk;
  logic            rst;
  logic            en;
  logic [4:0]      delay;
  logic [DWID-1:0] data_in;
  logic            valid_in;
  logic [DWID-1:0] data_out;
  logic            valid_out;

  int passes = 0;
  int total  = 0;

  ring_delay #(.data_width(DWID), .max_delay(MAXD)) dut (
    .clk(clk), .rst(rst), .en(en), .delay(delay),
    .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the line is a dq-stage shift register of the enabled samples since the last flush.
  typedef struct packed {
    logic            v;
    logic [DWID-1:0] d;
  } smp_t;

  smp_t            hist[$];
  int              m_dq = 1;
  logic [DWID-1:0] exp_d = '0;
  logic            exp_v = 1'b0;
  bit              live = 1'b0;

  function automatic int clampi(input int d);
    if (d == 0) return 1;
    if (d > MAXD) return MAXD;
    return d;
  endfunction

  always @(posedge clk) begin
    int cl;
    smp_t s;
    cl = clampi(int'(delay));
    if (rst) begin
      hist.delete();
      m_dq  = cl;
      exp_d = '0;
      exp_v = 1'b0;
      live  = 1'b1;
    end else if (cl != m_dq) begin
      hist.delete();
      m_dq  = cl;
      exp_d = '0;
      exp_v = 1'b0;
    end else if (en) begin
      hist.push_back({valid_in, data_in});
      if (hist.size() > MAXD) void'(hist.pop_front());
      if (hist.size() >= m_dq) begin
        s     = hist[hist.size() - m_dq];
        exp_d = s.d;
`ifdef RING_DELAY_VALID_EN
        exp_v = s.v;
`else
        exp_v = 1'b1;
`endif
      end else begin
        exp_d = '0;
        exp_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("stream_data", 32'(data_out), 32'(exp_d));
      check("stream_valid", 32'(valid_out), 32'(exp_v));
    end
  end

  task automatic cyc(input logic e, input logic [DWID-1:0] d, input logic v);
    en       = e;
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    delay    = 5'd3;
    data_in  = '0;
    valid_in = 1'b0;

    cyc(1'b1, 24'h999, 1'b1);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_valid", 32'(valid_out), 32'd0);
    rst = 1'b0;

    // delay 3, samples 1..5
    cyc(1'b1, 24'd1, 1'b1); check("d3_e0", 32'(data_out), 32'd0);
    cyc(1'b1, 24'd2, 1'b1); check("d3_e1", 32'(data_out), 32'd0);
    check("d3_v1", 32'(valid_out), 32'd0);
    cyc(1'b1, 24'd3, 1'b1); check("d3_e2", 32'(data_out), 32'd1);
    check("d3_v2", 32'(valid_out), 32'd1);
    cyc(1'b1, 24'd4, 1'b1); check("d3_e3", 32'(data_out), 32'd2);
    cyc(1'b1, 24'd5, 1'b1); check("d3_e4", 32'(data_out), 32'd3);

    // delay 1 acts as a plain register
    delay = 5'd1;
    cyc(1'b1, 24'h111111, 1'b1);
    check("flush1_data", 32'(data_out), 32'd0);
    check("flush1_valid", 32'(valid_out), 32'd0);
    cyc(1'b1, 24'hABCDEF, 1'b1); check("d1_dff", 32'(data_out), 32'hABCDEF);

    // delay 4 with gated enable
    delay = 5'd4;
    cyc(1'b0, 24'h999, 1'b1); check("flush4_data", 32'(data_out), 32'd0);
    cyc(1'b1, 24'd10, 1'b1);
    cyc(1'b0, 24'h999, 1'b1);
    cyc(1'b1, 24'd11, 1'b1);
    cyc(1'b0, 24'h999, 1'b1);
    cyc(1'b1, 24'd12, 1'b1); check("d4_en3", 32'(data_out), 32'd0);
    cyc(1'b0, 24'h999, 1'b1); check("d4_hold", 32'(data_out), 32'd0);
    cyc(1'b1, 24'd13, 1'b1); check("d4_en4", 32'(data_out), 32'd10);
    cyc(1'b0, 24'h999, 1'b1); check("d4_hold2", 32'(data_out), 32'd10);

    // delay 0 clamps to 1
    delay = 5'd0;
    cyc(1'b1, 24'h999, 1'b1); check("flush0_data", 32'(data_out), 32'd0);
    cyc(1'b1, 24'd77, 1'b1); check("d0_as_1", 32'(data_out), 32'd77);

    // delay 16 across two pointer wraps, then 31 must equal 16 (no flush)
    delay = 5'd16;
    cyc(1'b1, 24'h999, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 24'(100 + i), 1'b1);
      check("d16_wrap", 32'(data_out), (i >= 15) ? 32'(100 + i - 15) : 32'd0);
    end
    delay = 5'd31;
    for (int i = 40; i < 45; i++) begin
      cyc(1'b1, 24'(100 + i), 1'b1);
      check("d31_as_16", 32'(data_out), 32'(100 + i - 15));
    end

    // delay 5 stream, then switch to 2
    delay = 5'd5;
    cyc(1'b1, 24'd500, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 24'(1000 + i), 1'b1);
    check("d5_run", 32'(data_out), 32'd1005);
    delay = 5'd2;
    cyc(1'b1, 24'd2000, 1'b1);
    check("flush2_data", 32'(data_out), 32'd0);
    check("flush2_valid", 32'(valid_out), 32'd0);
    cyc(1'b1, 24'd2001, 1'b1); check("d2_fill", 32'(data_out), 32'd0);
    cyc(1'b1, 24'd2002, 1'b1); check("d2_first", 32'(data_out), 32'd2001);
    cyc(1'b1, 24'd2003, 1'b1); check("d2_next", 32'(data_out), 32'd2002);

    // reset mid-stream
    rst = 1'b1;
    cyc(1'b1, 24'd3000, 1'b1);
    check("rst_mid_data", 32'(data_out), 32'd0);
    check("rst_mid_valid", 32'(valid_out), 32'd0);
    rst = 1'b0;
    cyc(1'b1, 24'd3001, 1'b1); check("rst_refill", 32'(data_out), 32'd0);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) delay = 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 3) != 0, 24'($urandom), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    cyc(1'b0, 24'd0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
